// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel widths, kernel weights and FSM encoding for window3x3_filter
package img_pkg;

   localparam int PIX_WIDTH = 8;
   localparam int SUM_WIDTH = 12;

   localparam int W_CORNER = 1;
   localparam int W_EDGE   = 2;
   localparam int W_CENTER = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/window3x3_kernel.sv
// rtl/window3x3_kernel.sv - 3x3 window to registered filtered pixel
// Gaussian by default; Sobel magnitude when WINDOW3X3_SOBEL_EN is defined.
module window3x3_kernel #(
   parameter int PIX_WIDTH = 8
)(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en_i,
   input  logic [9*PIX_WIDTH-1:0] win_i,
   output logic [PIX_WIDTH-1:0]   pix_o
);
   import img_pkg::*;

   localparam int SW = PIX_WIDTH + 4;

   // p[row][col]: row 0 is the oldest line, col 0 the oldest column
   logic [SW-1:0]        p [0:2][0:2];
   logic [PIX_WIDTH-1:0] pix_d;

   for (genvar r = 0; r < 3; r++) begin : g_row
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign p[r][c] = {4'd0, win_i[(r*3+c)*PIX_WIDTH +: PIX_WIDTH]};
      end
   end

`ifdef WINDOW3X3_SOBEL_EN
   localparam logic [SW-1:0] WE      = SW'(W_EDGE);
   localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_WIDTH) - 1);

   logic signed [SW-1:0] gx, gy;
   logic [SW-1:0]        ax, ay, mag;

   always_comb begin
      gx    = $signed((p[0][2] + WE*p[1][2] + p[2][2]) - (p[0][0] + WE*p[1][0] + p[2][0]));
      gy    = $signed((p[2][0] + WE*p[2][1] + p[2][2]) - (p[0][0] + WE*p[0][1] + p[0][2]));
      ax    = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay    = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
      mag   = ax + ay;
      pix_d = (mag > PIX_MAX) ? PIX_MAX[PIX_WIDTH-1:0] : mag[PIX_WIDTH-1:0];
   end
`else
   localparam logic [SW-1:0] WC = SW'(W_CORNER);
   localparam logic [SW-1:0] WE = SW'(W_EDGE);
   localparam logic [SW-1:0] WX = SW'(W_CENTER);

   logic [SW-1:0] sum;

   // weights total 16, so the rounded sum always fits back into a pixel
   always_comb begin
      sum   = WC*(p[0][0] + p[0][2] + p[2][0] + p[2][2])
            + WE*(p[0][1] + p[1][0] + p[1][2] + p[2][1])
            + WX*p[1][1];
      pix_d = PIX_WIDTH'((sum + SW'(8)) >> 4);
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pix_o <= '0;
      end else if (en_i) begin
         pix_o <= pix_d;
      end
   end

endmodule

// File: rtl/window3x3_filter.sv
// rtl/window3x3_filter.sv - sliding 3x3 window over column stream with frame FSM and handshake
// Filter selected by WINDOW3X3_SOBEL_EN inside window3x3_kernel; ports identical in both builds.
module window3x3_filter #(
   parameter int DATA_WIDTH = 32,
   parameter int PIX_WIDTH  = 8
)(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start_op,
   input  logic [7:0]            width,
   input  logic [7:0]            height,
   input  logic [DATA_WIDTH-1:0] row0_pixel,
   input  logic [DATA_WIDTH-1:0] row1_pixel,
   input  logic [DATA_WIDTH-1:0] row2_pixel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_pixel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);
   import img_pkg::*;

   state_e                 state_q;
   logic [7:0]             width_q, height_q, col_q, row_q;
   logic                   last_col_taken_q, done_q, cfg_err_q;
   logic                   win_valid_q, out_valid_q;
   logic [9*PIX_WIDTH-1:0] win_q;
   logic [PIX_WIDTH-1:0]   new_col [0:2];
   logic [PIX_WIDTH-1:0]   kern_pix;
   logic                   en, accept, win_valid_d, last_out;
   logic                   unused_hi;

   assign new_col[0] = row0_pixel[PIX_WIDTH-1:0];
   assign new_col[1] = row1_pixel[PIX_WIDTH-1:0];
   assign new_col[2] = row2_pixel[PIX_WIDTH-1:0];
   assign unused_hi  = ^{row0_pixel[DATA_WIDTH-1:PIX_WIDTH],
                         row1_pixel[DATA_WIDTH-1:PIX_WIDTH],
                         row2_pixel[DATA_WIDTH-1:PIX_WIDTH]};

   assign en          = !out_valid_q || out_ready;
   assign in_ready    = (state_q == ST_RUN) && en && !last_col_taken_q;
   assign accept      = in_valid && in_ready;
   assign win_valid_d = accept && (col_q >= 8'd2);
   // once the final column is in, the final output is the one leaving with stage 1 empty
   assign last_out    = out_valid_q && out_ready && last_col_taken_q && !win_valid_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q          <= ST_IDLE;
         width_q          <= '0;
         height_q         <= '0;
         col_q            <= '0;
         row_q            <= '0;
         last_col_taken_q <= 1'b0;
         done_q           <= 1'b0;
         cfg_err_q        <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_op) begin
                  if (width >= 8'd3 && height >= 8'd3) begin
                     state_q          <= ST_RUN;
                     width_q          <= width;
                     height_q         <= height;
                     col_q            <= '0;
                     row_q            <= '0;
                     last_col_taken_q <= 1'b0;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (col_q == width_q - 8'd1) begin
                     col_q <= '0;
                     row_q <= row_q + 8'd1;
                     if (row_q == height_q - 8'd3) begin
                        last_col_taken_q <= 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 8'd1;
                  end
               end
               if (last_out) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         win_q       <= '0;
         win_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win_q[(r*3+0)*PIX_WIDTH +: PIX_WIDTH] <= win_q[(r*3+1)*PIX_WIDTH +: PIX_WIDTH];
               win_q[(r*3+1)*PIX_WIDTH +: PIX_WIDTH] <= win_q[(r*3+2)*PIX_WIDTH +: PIX_WIDTH];
               win_q[(r*3+2)*PIX_WIDTH +: PIX_WIDTH] <= new_col[r];
            end
         end
         if (en) begin
            win_valid_q <= win_valid_d;
            out_valid_q <= win_valid_q;
         end
      end
   end

   window3x3_kernel #(.PIX_WIDTH(PIX_WIDTH)) u_kernel (
      .clk   (clk),
      .rstn  (rstn),
      .en_i  (en),
      .win_i (win_q),
      .pix_o (kern_pix)
   );

   assign out_pixel = {{(DATA_WIDTH-PIX_WIDTH){1'b0}}, kern_pix};
   assign out_valid = out_valid_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_window3x3_filter.sv
// tb/tb_window3x3_filter.sv - self-checking bench for window3x3_filter
module tb_window3x3_filter;

   logic        clk = 1'b0;
   logic        rstn, start_op, in_valid, in_ready, out_valid, out_ready, busy, done, cfg_err;
   logic [7:0]  width, height;
   logic [31:0] row0_pixel, row1_pixel, row2_pixel, out_pixel;

   int checks = 0;
   int errors = 0;

   logic [7:0] img [0:15][0:15];

   typedef struct {
      int w; int h; int mode; int in_pct; int rdy_pct;
      int stall_at; int chk_lat; int exp_outs; int exp_first;
   } vec_t;

   vec_t vecs [8];

`ifdef WINDOW3X3_SOBEL_EN
   localparam int EXP_FLAT = 0;
   localparam int EXP_CTR  = 0;
   localparam int EXP_EDGE = 255;
`else
   localparam int EXP_FLAT = 16;
   localparam int EXP_CTR  = 64;
   localparam int EXP_EDGE = 191;
`endif

   always #5 clk = ~clk;

   window3x3_filter #(.DATA_WIDTH(32), .PIX_WIDTH(8)) dut (
      .clk(clk), .rstn(rstn), .start_op(start_op), .width(width), .height(height),
      .row0_pixel(row0_pixel), .row1_pixel(row1_pixel), .row2_pixel(row2_pixel),
      .in_valid(in_valid), .in_ready(in_ready), .out_pixel(out_pixel),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
      .cfg_err(cfg_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // expected output for the window whose rightmost column is c and top row is r
   function automatic int model(int r, int c);
`ifdef WINDOW3X3_SOBEL_EN
      int gx = 0, gy = 0, wt, mag;
      for (int d = 0; d < 3; d++) begin
         wt = (d == 1) ? 2 : 1;
         gx += wt * (int'(img[r+d][c]) - int'(img[r+d][c-2]));
         gy += wt * (int'(img[r+2][c-2+d]) - int'(img[r][c-2+d]));
      end
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (mag > 255) ? 255 : mag;
`else
      int sum = 0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            sum += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1) * int'(img[r+dr][c-2+dc]);
      return (sum + 8) / 16;
`endif
   endfunction

   task automatic fill_img(input int w, input int h, input int mode);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            case (mode)
               1:       img[r][c] = 8'd16;
               2:       img[r][c] = (r == 1 && c == 1) ? 8'd255 : 8'd0;
               3:       img[r][c] = (c == 0) ? 8'd0 : 8'd255;
               default: img[r][c] = 8'($urandom_range(0, 255));
            endcase
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int q[$];
      int k = 0, total, outs = 0, first_pix = -1, acc2 = -1, fov = -1, exp;
      int stall_cnt = 0, finished = 0;
      logic prev_stall = 1'b0, final_prev = 1'b0;
      logic [31:0] prev_pix = '0, tmp;
      fill_img(v.w, v.h, v.mode);
      total = (v.h - 2) * v.w;
      for (int r = 0; r <= v.h - 3; r++)
         for (int c = 2; c < v.w; c++)
            q.push_back(model(r, c));
      @(negedge clk);
      start_op = 1'b1; width = 8'(v.w); height = 8'(v.h); in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4000 && finished == 0; i++) begin
         @(negedge clk);
         start_op  = ($urandom_range(0, 7) == 0);
         width     = 8'($urandom_range(0, 20));
         height    = 8'($urandom_range(0, 20));
         in_valid  = ($urandom_range(1, 100) <= v.in_pct);
         tmp = $urandom(); row0_pixel = {tmp[31:8], (k < total) ? img[k/v.w][k%v.w]   : tmp[7:0]};
         tmp = $urandom(); row1_pixel = {tmp[31:8], (k < total) ? img[k/v.w+1][k%v.w] : tmp[7:0]};
         tmp = $urandom(); row2_pixel = {tmp[31:8], (k < total) ? img[k/v.w+2][k%v.w] : tmp[7:0]};
         out_ready = ($urandom_range(1, 100) <= v.rdy_pct);
         if (v.stall_at >= 0 && outs == v.stall_at && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
         end
         #1;
         chk($sformatf("v%0d done", idx), done, final_prev);
         chk($sformatf("v%0d busy", idx), busy, !final_prev);
         chk($sformatf("v%0d cfg_err", idx), cfg_err, 1'b0);
         if (final_prev) begin
            finished = 1;
         end else begin
            if (prev_stall) begin
               chk($sformatf("v%0d stall valid", idx), out_valid, 1'b1);
               chk($sformatf("v%0d stall pixel", idx), out_pixel, prev_pix);
            end
            if (out_valid && !out_ready)
               chk($sformatf("v%0d stall in_ready", idx), in_ready, 1'b0);
            if (k >= total)
               chk($sformatf("v%0d end in_ready", idx), in_ready, 1'b0);
            if (fov < 0 && out_valid) fov = i;
            if (in_valid && in_ready) begin
               if (k == 2) acc2 = i;
               k++;
            end
            if (out_valid && out_ready) begin
               if (q.size() > 0) begin
                  exp = q.pop_front();
                  chk($sformatf("v%0d pixel %0d", idx, outs), out_pixel, exp);
                  final_prev = (q.size() == 0);
               end
               if (first_pix < 0) first_pix = int'(out_pixel);
               outs++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pixel;
         end
      end
      start_op = 1'b0;
      in_valid = 1'b0;
      chk($sformatf("v%0d finished", idx), finished, 1);
      chk($sformatf("v%0d out count", idx), outs, v.exp_outs);
      if (v.exp_first >= 0) chk($sformatf("v%0d first pixel", idx), first_pix, v.exp_first);
      if (v.chk_lat != 0)   chk($sformatf("v%0d latency", idx), fov, acc2 + 2);
   endtask

   task automatic bad_cfg(input int w, input int h);
      @(negedge clk);
      start_op = 1'b1; width = 8'(w); height = 8'(h);
      @(negedge clk);
      start_op = 1'b0;
      #1;
      chk($sformatf("cfg %0dx%0d cfg_err", w, h), cfg_err, 1'b1);
      chk($sformatf("cfg %0dx%0d busy", w, h), busy, 1'b0);
      chk($sformatf("cfg %0dx%0d in_ready", w, h), in_ready, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("cfg %0dx%0d cfg_err clear", w, h), cfg_err, 1'b0);
      chk($sformatf("cfg %0dx%0d busy after", w, h), busy, 1'b0);
   endtask

   initial begin
      vec_t rv;
      rstn = 1'b0; start_op = 1'b0; width = '0; height = '0; in_valid = 1'b0; out_ready = 1'b1;
      row0_pixel = '0; row1_pixel = '0; row2_pixel = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_pixel", out_pixel, 32'd0);
      chk("reset in_ready", in_ready, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset cfg_err", cfg_err, 1'b0);
      rstn = 1'b1;

      vecs[0] = '{4,  3, 1, 100, 100, -1, 1,  2, EXP_FLAT};
      vecs[1] = '{3,  3, 2, 100, 100, -1, 1,  1, EXP_CTR};
      vecs[2] = '{8,  5, 0,  70,  60, -1, 0, 18, -1};
      vecs[3] = '{5,  4, 0, 100, 100, -1, 1,  6, -1};
      vecs[4] = '{16, 6, 0,  50,  40, -1, 0, 56, -1};
      vecs[5] = '{3,  7, 0,  80,  80, -1, 0,  5, -1};
      vecs[6] = '{8,  4, 0, 100, 100,  3, 1, 12, -1};
      vecs[7] = '{3,  3, 3, 100, 100, -1, 1,  1, EXP_EDGE};
      for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

      bad_cfg(2, 5);
      bad_cfg(5, 2);

      // reset in the middle of a frame after two columns
      @(negedge clk);
      start_op = 1'b1; width = 8'd6; height = 8'd3;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start_op = 1'b0; in_valid = 1'b1;
         row0_pixel = $urandom(); row1_pixel = $urandom(); row2_pixel = $urandom();
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("midreset busy", busy, 1'b0);
      chk("midreset in_ready", in_ready, 1'b0);
      chk("midreset out_valid", out_valid, 1'b0);
      chk("midreset out_pixel", out_pixel, 32'd0);
      chk("midreset done", done, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      rv = '{6, 3, 0, 100, 100, -1, 1, 4, -1};
      run_frame(rv, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
